// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture: rebuilds frames scanned out on the row/col display bus
// and commits each complete frame to a registered random-read display store.
module matrix_scan_capture #(
    parameter int X     = 16,
    parameter int Y     = 16,
    parameter int LOG2X = 4,
    parameter int LOG2Y = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Y-1:0]     row,
    input  logic [X-1:0]     col,
    input  logic             err_clr,
    input  logic [LOG2Y-1:0] rd_addr,
    output logic [X-1:0]     rd_data,
    output logic             frame_done,
    output logic             frame_valid,
    output logic [7:0]       frame_cnt,
    output logic             scan_err
);

    if ((1 << LOG2X) < X || (1 << LOG2Y) < Y) begin : g_bad_log2
        $error("matrix_scan_capture: LOG2X/LOG2Y too small for X/Y");
    end

    logic [X-1:0] shadow_q [Y];
    logic [X-1:0] shadow_d [Y];
    logic [X-1:0] disp_q   [Y];
    logic [X-1:0] disp_d   [Y];
    logic [Y-1:0] seen_q, seen_d;
    logic [X-1:0] rd_data_q, rd_data_d;
    logic         frame_done_q, frame_done_d;
    logic         frame_valid_q, frame_valid_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         scan_err_q, scan_err_d;

    logic row_any, row_multi, capture, commit;

    always_comb begin
        row_any   = |row;
        row_multi = (row & (row - Y'(1))) != '0;
        capture   = row_any && !row_multi;
        // the row being written this cycle counts towards completion
        commit    = capture && (&(seen_q | row));

        shadow_d = shadow_q;
        disp_d   = disp_q;
        seen_d   = seen_q;

        if (capture) begin
            for (int unsigned r = 0; r < Y; r++) begin
                if (row[r]) shadow_d[r] = col;
            end
            seen_d = commit ? '0 : (seen_q | row);
        end
        if (commit) disp_d = shadow_d;

        frame_done_d  = commit;
        frame_valid_d = frame_valid_q | commit;
        frame_cnt_d   = frame_cnt_q + 8'(commit);

        if (row_multi)    scan_err_d = 1'b1;
        else if (err_clr) scan_err_d = 1'b0;
        else              scan_err_d = scan_err_q;

        rd_data_d = '0;
        if (int'(rd_addr) < Y) rd_data_d = disp_q[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q      <= '{default: '0};
            disp_q        <= '{default: '0};
            seen_q        <= '0;
            rd_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
            scan_err_q    <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            seen_q        <= seen_d;
            rd_data_q     <= rd_data_d;
            frame_done_q  <= frame_done_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
            scan_err_q    <= scan_err_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_done  = frame_done_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign scan_err    = scan_err_q;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Bench for matrix_scan_capture: directed scenarios plus randomized scans,
// every output compared each cycle against a frame-level reference model.
module tb_matrix_scan_capture;
    localparam int X = 16;
    localparam int Y = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] row = '0;
    logic [15:0] col = '0;
    logic        err_clr = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        frame_done;
    logic        frame_valid;
    logic [7:0]  frame_cnt;
    logic        scan_err;

    matrix_scan_capture #(.X(X), .Y(Y), .LOG2X(4), .LOG2Y(4)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .err_clr(err_clr),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done),
        .frame_valid(frame_valid), .frame_cnt(frame_cnt), .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int dut_done = 0;

    // reference model: frames as arrays of rows, completion = every row flagged seen
    bit [15:0] m_shadow [16];
    bit [15:0] m_disp   [16];
    bit        m_seen   [16];
    int        m_cnt;
    bit        m_valid;
    bit        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = '0;
            m_disp[i]   = '0;
            m_seen[i]   = 1'b0;
        end
        m_cnt = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_valid"}, frame_valid, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_scan_err"}, scan_err, 0);
    endtask

    task automatic do_reset(input int cycles);
        row = '0; col = '0; err_clr = 1'b0; rd_addr = '0;
        reset = 1'b0;
        model_clear();
        #1;
        chk_zero("reset_async");
        repeat (cycles) @(negedge clk);
        chk_zero("reset_held");
        reset = 1'b1;
    endtask

    task automatic step(input logic [15:0] r, input logic [15:0] c,
                        input logic clr, input logic [3:0] a);
        bit [15:0] exp_rd;
        bit        exp_done;
        bit        all;
        int        n;
        int        idx;
        row = r; col = c; err_clr = clr; rd_addr = a;
        @(posedge clk);
        exp_rd   = m_disp[a];
        exp_done = 1'b0;
        n = $countones(r);
        idx = 0;
        if (n == 1) begin
            for (int i = 0; i < 16; i++) if (r[i]) idx = i;
            m_shadow[idx] = c;
            m_seen[idx]   = 1'b1;
            all = 1'b1;
            for (int i = 0; i < 16; i++) if (!m_seen[i]) all = 1'b0;
            if (all) begin
                m_disp = m_shadow;
                for (int i = 0; i < 16; i++) m_seen[i] = 1'b0;
                exp_done = 1'b1;
                m_cnt    = (m_cnt + 1) % 256;
                m_valid  = 1'b1;
            end
        end
        if (n >= 2)   m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        #1;
        chk("rd_data", rd_data, exp_rd);
        chk("frame_done", frame_done, exp_done);
        chk("frame_valid", frame_valid, m_valid);
        chk("frame_cnt", frame_cnt, m_cnt);
        chk("scan_err", scan_err, m_err);
        if (frame_done === 1'b1) dut_done++;
        @(negedge clk);
    endtask

    function automatic logic [15:0] onehot(input int r);
        logic [15:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] plus_row(input int r);
        case (r)
            7:       return 16'h0100;
            8:       return 16'h0380;
            9:       return 16'h0100;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        logic [15:0] a8, b8, v;
        int          base_cnt;
        int          ord [16];
        int          j, t;

        #2;
        do_reset(2);

        // plus-shaped frame, rows in order
        dut_done = 0;
        for (int r = 0; r < 16; r++) step(onehot(r), plus_row(r), 1'b0, 4'd8);
        chk("plus_done_pulses", dut_done, 1);
        chk("plus_frame_cnt", frame_cnt, 1);
        chk("plus_frame_valid", frame_valid, 1);
        step('0, '0, 1'b0, 4'd8);
        chk("plus_row8", rd_data, 16'h0380);

        // reverse order with row 3 rescanned before completion
        dut_done = 0;
        for (int r = 15; r >= 0; r--) begin
            if (r == 3) begin
                step(onehot(3), 16'hAAAA, 1'b0, 4'd0);
                step(onehot(3), 16'h5555, 1'b0, 4'd0);
            end else begin
                step(onehot(r), 16'($urandom), 1'b0, 4'($urandom));
            end
        end
        step('0, '0, 1'b0, 4'd3);
        chk("rev_done_pulses", dut_done, 1);
        chk("rev_row3", rd_data, 16'h5555);
        chk("rev_scan_err", scan_err, 0);

        // multi-hot sample mid-frame, then error clear interactions
        base_cnt = m_cnt;
        for (int r = 0; r < 5; r++) step(onehot(r), 16'($urandom), 1'b0, 4'($urandom));
        step(16'h0003, 16'hFFFF, 1'b0, 4'd0);
        chk("multi_scan_err", scan_err, 1);
        chk("multi_no_commit", frame_cnt, base_cnt);
        for (int r = 5; r < 16; r++) step(onehot(r), 16'($urandom), 1'b0, 4'($urandom));
        chk("multi_then_commit", frame_cnt, base_cnt + 1);
        step('0, '0, 1'b1, 4'd0);
        chk("err_clr", scan_err, 0);
        step(16'h0005, '0, 1'b1, 4'd0);
        chk("err_beats_clr", scan_err, 1);

        // read held on row 8 across a commit
        for (int r = 0; r < 16; r++) step(onehot(r), 16'($urandom), 1'b0, 4'd8);
        a8 = m_disp[8];
        for (int r = 0; r < 16; r++) begin
            v = (r == 8) ? ~a8 : 16'($urandom);
            step(onehot(r), v, 1'b0, 4'd8);
        end
        chk("commit_edge_old_row8", rd_data, a8);
        b8 = ~a8;
        step('0, '0, 1'b0, 4'd8);
        chk("next_edge_new_row8", rd_data, b8);

        // reset mid-frame discards partial scan
        for (int r = 0; r < 10; r++) step(onehot(r), 16'($urandom), 1'b0, 4'($urandom));
        do_reset(3);
        dut_done = 0;
        for (int r = 10; r < 16; r++) step(onehot(r), 16'($urandom), 1'b0, 4'($urandom));
        chk("post_reset_no_commit", frame_cnt, 0);
        for (int r = 0; r < 16; r++) step(onehot(r), 16'($urandom), 1'b0, 4'($urandom));
        chk("post_reset_one_commit", dut_done, 1);
        chk("post_reset_frame_cnt", frame_cnt, 1);
        for (int a = 0; a < 16; a++) step('0, '0, 1'b0, 4'(a));

        // randomized bus traffic including blanking, repeats and multi-hot
        for (int i = 0; i < 400; i++) begin
            t = $urandom_range(9, 0);
            if (t < 2)       v = '0;
            else if (t == 2) v = onehot($urandom_range(15, 0)) | onehot($urandom_range(15, 0)) | 16'h8001;
            else             v = onehot($urandom_range(15, 0));
            step(v, 16'($urandom), ($urandom_range(9, 0) == 0), 4'($urandom));
        end

        // 257 frames in shuffled row order to wrap the frame counter
        do_reset(2);
        dut_done = 0;
        for (int f = 0; f < 257; f++) begin
            for (int i = 0; i < 16; i++) ord[i] = i;
            for (int i = 15; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(7, 0) == 0) step('0, 16'($urandom), 1'b0, 4'($urandom));
                step(onehot(ord[i]), 16'($urandom), 1'b0, 4'($urandom));
            end
        end
        chk("wrap_done_pulses", dut_done, 257);
        chk("wrap_frame_cnt", frame_cnt, 1);
        chk("wrap_frame_valid", frame_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
